sd_run_controller: RTL and testbench

Run sequencer for the three-node coupled sigma-delta network. It accepts a run request from the host, drives the shared coupling constant `kin` into the network, and waits a settle period. It then counts ones on each of the three bitstream outputs over a measurement window and presents the three counts to the host through a valid/ready handshake. It sits between the host register interface and the network's `kin` input and `sd_out[2:0]` output.

---
 rtl/sd_run_controller.sv | 137 +++++++++++++
 tb/tb_sd_run_controller.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sd_run_controller.sv
// Run sequencer for the coupled sigma-delta network: drives kin, settles, counts ones per channel, hands off results.
// Optional per-channel toggle counters are compiled in with SD_TOGGLE_CNT_EN.
module sd_run_controller #(
  parameter int BITWIDTH = 32,
  parameter int CNTW     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [BITWIDTH-1:0] k_value,
  input  logic [15:0]         settle_len,
  input  logic [15:0]         window_len,
  input  logic [2:0]          sd_in,
  output logic [BITWIDTH-1:0] kin,
  output logic                busy,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [CNTW-1:0]     ones0,
  output logic [CNTW-1:0]     ones1,
  output logic [CNTW-1:0]     ones2,
`ifdef SD_TOGGLE_CNT_EN
  output logic [CNTW-1:0]     tog0,
  output logic [CNTW-1:0]     tog1,
  output logic [CNTW-1:0]     tog2,
`endif
  output logic [1:0]          fsm_state
);

  // Handshake: a result transfers on a rising edge where res_valid and res_ready are both high;
  // res_ready is ignored while res_valid is low, and res_valid holds until that edge.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            state, state_next;
  logic [15:0]       cnt;
  logic [15:0]       win_q;
  logic [15:0]       win_eff;
  logic [CNTW-1:0]   ones_q [3];

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v, input logic b);
    return (b && (v != {CNTW{1'b1}})) ? v + CNTW'(1) : v;
  endfunction

  assign win_eff   = (window_len == 16'd0) ? 16'd1 : window_len;
  assign busy      = (state != IDLE);
  assign res_valid = (state == DONE);
  assign fsm_state = state;
  assign ones0     = ones_q[0];
  assign ones1     = ones_q[1];
  assign ones2     = ones_q[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (settle_len != 16'd0) ? SETTLE : MEASURE;
      SETTLE:  if (cnt == 16'd1) state_next = MEASURE;
      MEASURE: if (cnt == 16'd1) state_next = DONE;
      DONE:    if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  // One down-counter serves both phases; it is reloaded with the window length on leaving SETTLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kin   <= '0;
      cnt   <= '0;
      win_q <= '0;
      for (int i = 0; i < 3; i++) ones_q[i] <= '0;
    end else if (abort) begin
      kin <= '0;
      cnt <= '0;
      for (int i = 0; i < 3; i++) ones_q[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          for (int i = 0; i < 3; i++) ones_q[i] <= '0;
          if (start) begin
            kin   <= k_value;
            win_q <= win_eff;
            cnt   <= (settle_len != 16'd0) ? settle_len : win_eff;
          end
        end
        SETTLE: cnt <= (cnt == 16'd1) ? win_q : cnt - 16'd1;
        MEASURE: begin
          cnt <= cnt - 16'd1;
          for (int i = 0; i < 3; i++) ones_q[i] <= sat_inc(ones_q[i], sd_in[i]);
        end
        DONE: begin
          if (res_ready) begin
            kin <= '0;
            for (int i = 0; i < 3; i++) ones_q[i] <= '0;
          end
        end
        default: kin <= '0;
      endcase
    end
  end

`ifdef SD_TOGGLE_CNT_EN
  logic [2:0]      sd_prev;
  logic [CNTW-1:0] tog_q [3];
  logic            tog_clr;

  assign tog0    = tog_q[0];
  assign tog1    = tog_q[1];
  assign tog2    = tog_q[2];
  assign tog_clr = abort || (state == IDLE) || ((state == DONE) && res_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sd_prev <= '0;
      for (int i = 0; i < 3; i++) tog_q[i] <= '0;
    end else begin
      sd_prev <= sd_in;
      if (tog_clr) begin
        for (int i = 0; i < 3; i++) tog_q[i] <= '0;
      end else if (state == MEASURE) begin
        for (int i = 0; i < 3; i++) tog_q[i] <= sat_inc(tog_q[i], sd_in[i] ^ sd_prev[i]);
      end
    end
  end
`endif

endmodule

// File: tb/tb_sd_run_controller.sv
// Bench for sd_run_controller: table-driven runs through a result scoreboard, plus abort/restart/reset sequences.
// Toggle counter checks are compiled in with SD_TOGGLE_CNT_EN.
module tb_sd_run_controller;

  localparam int BW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [BW-1:0] k_value = '0;
  logic [15:0]   settle_len = '0;
  logic [15:0]   window_len = '0;
  logic [2:0]    sd_in = '0;
  logic          res_ready = 1'b0;
  logic [BW-1:0] kin;
  logic          busy;
  logic          res_valid;
  logic [CW-1:0] ones0, ones1, ones2;
  logic [1:0]    fsm_state;
`ifdef SD_TOGGLE_CNT_EN
  logic [CW-1:0] tog0, tog1, tog2;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [BW-1:0] k;
    logic [15:0]   s;
    logic [15:0]   w;
    logic [2:0]    sd;
    logic          alt;
    logic [CW-1:0] o0, o1, o2, t0;
    int            lat;
  } vec_t;

  logic [4*CW-1:0] exp_q[$];
  int              lat_q[$];
  vec_t            vecs[$];

  sd_run_controller #(.BITWIDTH(BW), .CNTW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .k_value(k_value), .settle_len(settle_len), .window_len(window_len), .sd_in(sd_in),
    .kin(kin), .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .ones0(ones0), .ones1(ones1), .ones2(ones2),
`ifdef SD_TOGGLE_CNT_EN
    .tog0(tog0), .tog1(tog1), .tog2(tog2),
`endif
    .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " kin"}, 64'(kin), 64'd0);
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " res_valid"}, 64'(res_valid), 64'd0);
    check({tag, " ones"}, 64'({ones2, ones1, ones0}), 64'd0);
`ifdef SD_TOGGLE_CNT_EN
    check({tag, " tog"}, 64'({tog2, tog1, tog0}), 64'd0);
`endif
  endtask

  // Advance one edge and sample 1ns later; counts edges into n.
  task automatic step(inout int n);
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n;
    logic [4*CW-1:0] e;
    logic [4*CW-1:0] got;
    n = 0;
    @(negedge clk);
    k_value = v.k; settle_len = v.s; window_len = v.w; sd_in = v.sd; start = 1'b1;
    exp_q.push_back({v.t0, v.o2, v.o1, v.o0});
    lat_q.push_back(v.lat);
    step(n);
    start = 1'b0;
    check($sformatf("v%0d kin at start", idx), 64'(kin), 64'(v.k));
    check($sformatf("v%0d busy at start", idx), 64'(busy), 64'd1);
    if (v.alt) sd_in[0] = ~sd_in[0];
    while (!res_valid && n < 200) begin
      step(n);
      if (v.alt) sd_in[0] = ~sd_in[0];
    end
    check($sformatf("v%0d res_valid seen", idx), 64'(res_valid), 64'd1);
    e = exp_q.pop_front();
    check($sformatf("v%0d latency", idx), 64'(n), 64'(lat_q.pop_front()));
    check($sformatf("v%0d ones", idx), 64'({ones2, ones1, ones0}), 64'(e[3*CW-1:0]));
    check($sformatf("v%0d kin in done", idx), 64'(kin), 64'(v.k));
`ifdef SD_TOGGLE_CNT_EN
    check($sformatf("v%0d tog0", idx), 64'(tog0), 64'(e[4*CW-1:3*CW]));
`endif
    got = {4'h0, ones2, ones1, ones0};
    step(n);
    check($sformatf("v%0d res_valid held", idx), 64'(res_valid), 64'd1);
    check($sformatf("v%0d ones stable", idx), 64'({4'h0, ones2, ones1, ones0}), 64'(got));
    @(negedge clk);
    res_ready = 1'b1;
    step(n);
    res_ready = 1'b0;
    check_outputs_zero($sformatf("v%0d after accept", idx));
  endtask

  initial begin
    int n;
    vec_t v;

    #1;
    check_outputs_zero("in reset");
    check("reset state", 64'(fsm_state), 64'd0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outputs_zero("after reset release");

    vecs.push_back('{k: 32'd5,          s: 16'd4, w: 16'd10, sd: 3'b101, alt: 1'b0,
                     o0: 4'd10, o1: 4'd0, o2: 4'd10, t0: 4'd0, lat: 15});
    vecs.push_back('{k: 32'd1,          s: 16'd0, w: 16'd0,  sd: 3'b111, alt: 1'b0,
                     o0: 4'd1,  o1: 4'd1, o2: 4'd1,  t0: 4'd0, lat: 2});
    vecs.push_back('{k: 32'hDEADBEEF,   s: 16'd0, w: 16'd20, sd: 3'b001, alt: 1'b0,
                     o0: 4'd15, o1: 4'd0, o2: 4'd0,  t0: 4'd0, lat: 21});
    vecs.push_back('{k: 32'd7,          s: 16'd2, w: 16'd3,  sd: 3'b010, alt: 1'b0,
                     o0: 4'd0,  o1: 4'd3, o2: 4'd0,  t0: 4'd0, lat: 6});
    vecs.push_back('{k: 32'd3,          s: 16'd1, w: 16'd8,  sd: 3'b010, alt: 1'b1,
                     o0: 4'd4,  o1: 4'd8, o2: 4'd0,  t0: 4'd8, lat: 10});
    for (int i = 0; i < 4; i++) begin
      v.k   = $urandom;
      v.s   = 16'($urandom_range(0, 6));
      v.w   = 16'($urandom_range(1, 12));
      v.sd  = 3'($urandom_range(0, 7));
      v.alt = 1'b0;
      v.o0  = v.sd[0] ? CW'(v.w) : '0;
      v.o1  = v.sd[1] ? CW'(v.w) : '0;
      v.o2  = v.sd[2] ? CW'(v.w) : '0;
      v.t0  = '0;
      v.lat = int'(v.s) + int'(v.w) + 1;
      vecs.push_back(v);
    end
    foreach (vecs[i]) run_vec(vecs[i], i);

    // Abort in the third MEASURE cycle (S=2 puts MEASURE after the third edge).
    n = 0;
    @(negedge clk);
    k_value = 32'd11; settle_len = 16'd2; window_len = 16'd10; sd_in = 3'b111; start = 1'b1;
    step(n);
    start = 1'b0;
    repeat (4) step(n);
    check("abort pre state", 64'(fsm_state), 64'd2);
    abort = 1'b1;
    step(n);
    abort = 1'b0;
    check("abort state", 64'(fsm_state), 64'd0);
    check_outputs_zero("after abort");

    // Start pulsed during SETTLE is ignored; res_ready held early accepts in the first DONE cycle.
    n = 0;
    @(negedge clk);
    k_value = 32'd9; settle_len = 16'd5; window_len = 16'd2; sd_in = 3'b100; start = 1'b1;
    step(n);
    start = 1'b0;
    step(n);
    k_value = 32'd3; start = 1'b1;
    step(n);
    start = 1'b0;
    check("kin after mid-settle start", 64'(kin), 64'd9);
    res_ready = 1'b1;
    while (!res_valid && n < 200) step(n);
    check("restart latency", 64'(n), 64'd8);
    check("restart kin in done", 64'(kin), 64'd9);
    check("restart ones", 64'({ones2, ones1, ones0}), 64'({4'd2, 4'd0, 4'd0}));
    step(n);
    res_ready = 1'b0;
    check_outputs_zero("early ready accept");

    // Asynchronous reset during DONE.
    n = 0;
    @(negedge clk);
    k_value = 32'd13; settle_len = 16'd0; window_len = 16'd7; sd_in = 3'b001; start = 1'b1;
    step(n);
    start = 1'b0;
    while (!res_valid && n < 200) step(n);
    check("pre-reset res_valid", 64'(res_valid), 64'd1);
    check("pre-reset ones0", 64'(ones0), 64'd7);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async reset");
    @(negedge clk);
    rst_n = 1'b1;

    check("scoreboard drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
